// File: rtl/axi_write_sink.sv
// AXI3-style write-channel slave: terminates AW/W bursts into a small word memory,
// returns one B response per burst and counts completed and errored bursts.
module axi_write_sink #(
  parameter int unsigned PID_WIDTH     = 4,
  parameter int unsigned PADDR_WIDTH   = 32,
  parameter int unsigned PLENGTH_WIDTH = 4,
  parameter int unsigned PSIZE_WIDTH   = 3,
  parameter int unsigned PAWUSER_WIDTH = 2,
  parameter int unsigned POTHER        = 4,
  parameter int unsigned PDATA_WIDTH   = 8,
  parameter int unsigned MEM_DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [PID_WIDTH-1:0]         awid,
  input  logic [PADDR_WIDTH-1:0]       awaddr,
  input  logic [PLENGTH_WIDTH-1:0]     awlen,
  input  logic [PSIZE_WIDTH-1:0]       awsize,
  input  logic [1:0]                   awburst,
  input  logic [PAWUSER_WIDTH-1:0]     awuser,
  input  logic [POTHER-1:0]            other,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [PID_WIDTH-1:0]         wid,
  input  logic [8*PDATA_WIDTH-1:0]     wdata,
  input  logic [PDATA_WIDTH-1:0]       wstrb,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [PID_WIDTH-1:0]         bid,
  output logic [1:0]                   bresp,
  input  logic                         rd_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [8*PDATA_WIDTH-1:0]     rd_data,
  output logic [15:0]                  burst_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned LANE_BITS  = $clog2(PDATA_WIDTH);
  localparam int unsigned IDX_BITS   = $clog2(MEM_DEPTH);
  // One extra bit so the beat index can run past len without wrapping back into range
  localparam int unsigned BEAT_WIDTH = PLENGTH_WIDTH + 1;
  localparam logic [PADDR_WIDTH-1:0] MEM_BYTES = PADDR_WIDTH'(MEM_DEPTH * PDATA_WIDTH);
  localparam logic [PSIZE_WIDTH-1:0] MAX_SIZE  = PSIZE_WIDTH'(LANE_BITS);

  typedef enum logic [1:0] {StInit, StIdle, StData, StResp} state_e;

  state_e                   state_q, state_d;
  logic [PID_WIDTH-1:0]     id_q;
  logic [PADDR_WIDTH-1:0]   addr_q;
  logic [PLENGTH_WIDTH-1:0] len_q;
  logic [PSIZE_WIDTH-1:0]   size_q;
  logic [1:0]               burst_q;
  logic [BEAT_WIDTH-1:0]    beat_q;
  logic                     dec_q, slv_q;
  logic [PID_WIDTH-1:0]     bid_q;
  logic [1:0]               bresp_q;
  logic [15:0]              burst_cnt_q, err_cnt_q;

  logic [8*PDATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic aw_hs, w_hs, b_hs;
  logic wid_ok, beat_in_range, beat_err, mem_we;
  logic [BEAT_WIDTH-1:0]  len_ext;
  logic [PADDR_WIDTH-1:0] step, wrap_mask, addr_inc, addr_next;
  logic [IDX_BITS-1:0]    wr_idx;
  logic                   unused_inputs;

  assign unused_inputs = ^{awuser, other};

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  assign len_ext       = {1'b0, len_q};
  assign wid_ok        = (wid == id_q);
  assign beat_in_range = (beat_q <= len_ext);
  assign beat_err      = !wid_ok || !beat_in_range || (wlast && (beat_q < len_ext));
  assign mem_we        = w_hs && !dec_q && wid_ok && beat_in_range && (burst_q != 2'd3);
  assign wr_idx        = addr_q[LANE_BITS +: IDX_BITS];

  assign step      = PADDR_WIDTH'(1) << size_q;
  assign wrap_mask = ((PADDR_WIDTH'(len_q) + PADDR_WIDTH'(1)) << size_q) - PADDR_WIDTH'(1);
  assign addr_inc  = addr_q + step;

  // Next beat address: FIXED holds, INCR steps, WRAP steps inside the aligned window
  always_comb begin
    addr_next = addr_q;
    unique case (burst_q)
      2'd1:    addr_next = addr_inc;
      2'd2:    addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StInit;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs, decoded from the state flop only
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        awready = 1'b1;
        if (awvalid) state_d = StData;
      end
      StData: begin
        wready = 1'b1;
        if (wvalid && wlast) state_d = StResp;
      end
      StResp: begin
        bvalid = 1'b1;
        if (bready) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // Burst context, sticky error flags, response and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      dec_q       <= 1'b0;
      slv_q       <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (aw_hs) begin
        id_q    <= awid;
        addr_q  <= awaddr;
        len_q   <= awlen;
        size_q  <= awsize;
        burst_q <= awburst;
        beat_q  <= '0;
        dec_q   <= (awaddr >= MEM_BYTES) || (awsize > MAX_SIZE);
        slv_q   <= (awburst == 2'd3);
      end
      if (w_hs) begin
        addr_q <= addr_next;
        if (beat_q != '1) beat_q <= beat_q + BEAT_WIDTH'(1);
        slv_q <= slv_q | beat_err;
        if (wlast) begin
          bid_q   <= id_q;
          bresp_q <= dec_q ? 2'b11 : ((slv_q | beat_err) ? 2'b10 : 2'b00);
        end
      end
      if (b_hs) begin
        burst_cnt_q <= burst_cnt_q + 16'd1;
        if ((bresp_q != 2'b00) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  // Byte-masked memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < int'(PDATA_WIDTH); i++) begin
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Debug read port; a same-cycle write is seen on the following read only
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign burst_cnt = burst_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_write_sink.sv
// Directed bench for axi_write_sink: drives and samples on the falling edge.
module tb_axi_write_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awuser;
  logic [3:0]  other;
  logic        wvalid, wready;
  logic [3:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_data;
  logic [15:0] burst_cnt, err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  axi_write_sink dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awuser(awuser), .other(other),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .burst_cnt(burst_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", {63'd0, awready}, 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic [63:0] data, input logic [7:0] strb,
                        input logic last);
    int n = 0;
    wvalid = 1'b1; wid = id; wdata = data; wstrb = strb; wlast = last;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", {63'd0, wready}, 64'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [3:0] exp_id, input logic [1:0] exp_resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
    check({tag, "_bid"}, {60'd0, bid}, {60'd0, exp_id});
    check({tag, "_bresp"}, {62'd0, bresp}, {62'd0, exp_resp});
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [7:0] idx, input logic [63:0] exp);
    rd_en = 1'b1; rd_addr = idx;
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awuser = 0; other = 0;
    wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; rd_en = 0; rd_addr = 0;
    repeat (2) @(negedge clk);
    check("rst_awready", {63'd0, awready}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
    check("rst_cnt", {32'd0, burst_cnt, err_cnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {63'd0, awready}, 64'd1);
    check("idle_wready", {63'd0, wready}, 64'd0);

    // Single beat to word 2
    send_aw(4'd3, 32'h10, 4'd0, 3'd3, 2'd1);
    check("t1_wready", {63'd0, wready}, 64'd1);
    send_w(4'd3, 64'h1122334455667788, 8'hFF, 1'b1);
    get_b("t1", 4'd3, 2'b00);
    check("t1_awready_after_b", {63'd0, awready}, 64'd1);
    read_word("t1_word2", 8'd2, 64'h1122334455667788);
    check("t1_burst_cnt", {48'd0, burst_cnt}, 64'd1);
    check("t1_err_cnt", {48'd0, err_cnt}, 64'd0);

    // Seed word 1 so the partial-strobe beat below has a known upper half
    send_aw(4'd1, 32'h08, 4'd0, 3'd3, 2'd1);
    send_w(4'd1, 64'hAAAAAAAABBBBBBBB, 8'hFF, 1'b1);
    get_b("seed", 4'd1, 2'b00);

    // INCR 4 beats at 0, low-half strobe on the second beat
    send_aw(4'd2, 32'h0, 4'd3, 3'd3, 2'd1);
    send_w(4'd2, 64'd1, 8'hFF, 1'b0);
    send_w(4'd2, 64'd2, 8'h0F, 1'b0);
    send_w(4'd2, 64'd3, 8'hFF, 1'b0);
    send_w(4'd2, 64'd4, 8'hFF, 1'b1);
    check("t2_bvalid_next", {63'd0, bvalid}, 64'd1);
    get_b("t2", 4'd2, 2'b00);
    read_word("t2_word0", 8'd0, 64'd1);
    read_word("t2_word1", 8'd1, 64'hAAAAAAAA00000002);
    read_word("t2_word2", 8'd2, 64'd3);
    read_word("t2_word3", 8'd3, 64'd4);

    // WRAP len=3 from 0x10: words 2,3,0,1
    send_aw(4'd4, 32'h10, 4'd3, 3'd3, 2'd2);
    send_w(4'd4, 64'h10, 8'hFF, 1'b0);
    send_w(4'd4, 64'h20, 8'hFF, 1'b0);
    send_w(4'd4, 64'h30, 8'hFF, 1'b0);
    send_w(4'd4, 64'h40, 8'hFF, 1'b1);
    get_b("t3", 4'd4, 2'b00);
    read_word("t3_word2", 8'd2, 64'h10);
    read_word("t3_word3", 8'd3, 64'h20);
    read_word("t3_word0", 8'd0, 64'h30);
    read_word("t3_word1", 8'd1, 64'h40);

    // Wrong wid on first beat: that beat dropped, second beat written, SLVERR
    send_aw(4'd3, 32'h0, 4'd1, 3'd3, 2'd1);
    send_w(4'd5, 64'h55, 8'hFF, 1'b0);
    send_w(4'd3, 64'h66, 8'hFF, 1'b1);
    get_b("t4", 4'd3, 2'b10);
    check("t4_err_cnt", {48'd0, err_cnt}, 64'd1);
    read_word("t4_word0", 8'd0, 64'h30);
    read_word("t4_word1", 8'd1, 64'h66);

    // Early wlast on beat 0 of len=3
    send_aw(4'd6, 32'h18, 4'd3, 3'd3, 2'd1);
    send_w(4'd6, 64'h77, 8'hFF, 1'b1);
    get_b("t5", 4'd6, 2'b10);
    check("t5_awready", {63'd0, awready}, 64'd1);
    check("t5_err_cnt", {48'd0, err_cnt}, 64'd2);
    read_word("t5_word3", 8'd3, 64'h77);

    // Out-of-range address: DECERR, no writes; B held with bready low
    send_aw(4'd7, 32'h800, 4'd1, 3'd3, 2'd1);
    send_w(4'd7, 64'h99, 8'hFF, 1'b0);
    send_w(4'd7, 64'h9A, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_b", {58'd0, bvalid, bid, bresp}, {58'd0, 1'b1, 4'd7, 2'b11});
      @(negedge clk);
    end
    get_b("t6", 4'd7, 2'b11);
    check("t6_cnts", {32'd0, burst_cnt, err_cnt}, {32'd0, 16'd7, 16'd3});
    read_word("t6_word0", 8'd0, 64'h30);
    read_word("t6_word1", 8'd1, 64'h66);

    // Reset during the third beat of a four-beat burst
    send_aw(4'd8, 32'h28, 4'd3, 3'd3, 2'd1);
    send_w(4'd8, 64'hB0, 8'hFF, 1'b0);
    send_w(4'd8, 64'hB1, 8'hFF, 1'b0);
    wvalid = 1'b1; wid = 4'd8; wdata = 64'hB2; wstrb = 8'hFF;
    #2 rst = 1'b1;
    #1;
    check("t7_rst_out", {57'd0, awready, wready, bvalid, bid, bresp} , 64'd0);
    check("t7_rst_cnt", {32'd0, burst_cnt, err_cnt}, 64'd0);
    wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t7_awready", {63'd0, awready}, 64'd1);
    check("t7_no_b", {63'd0, bvalid}, 64'd0);
    check("t7_burst_cnt", {48'd0, burst_cnt}, 64'd0);
    read_word("t7_word5", 8'd5, 64'hB0);
    read_word("t7_word6", 8'd6, 64'hB1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
